imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Parametrised, clocked successor to the combinational instruction ROM: byte-addressed, little-endian 32-bit instruction store with a valid/ready fetch port and 1-cycle registered read.
- Adds a word-write load port with a BOOT/RUN mode FSM, flush, alignment/range fault reporting and a delivered-fetch counter.
- Sits between the IF-stage PC logic and the IF/ID pipeline register.

Parameters:
- DEPTH_BYTES, 256, storage size in bytes; multiple of 4, power of two.
- ADDR_W, 64, width of fetch address.
- BOOT_LOAD, 1, 1 = leave reset in BOOT (wait for loader); 0 = leave reset in RUN.
- NOP_WORD, 32'h00000013, instruction returned on a faulting fetch.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  byte address (PC).
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_inst  out  32  instruction {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- resp_addr  out  ADDR_W  address of the returned instruction.
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range (misaligned wins if both).
- flush  in  1  discard held or pending response.
- ld_en  in  1  write one word.
- ld_word_addr  in  log2(DEPTH_BYTES/4)  word index.
- ld_data  in  32  word written little-endian into 4 bytes.
- ld_done  in  1  BOOT -> RUN.
- booting  out  1  high in BOOT.
- fetch_count  out  32  count of responses handed off (resp_valid & resp_ready); wraps.

Behaviour:
- Reset (reset==0 at edge): resp_valid=0, resp_inst=0, resp_addr=0, resp_fault=00, fetch_count=0, state=BOOT if BOOT_LOAD else RUN. Memory contents are NOT cleared by reset.
- FSM states:
  - BOOT: req_ready=0, booting=1. ld_done=1 -> RUN next cycle. A load with ld_en and ld_done in the same cycle is performed.
  - RUN: booting=0. Stays in RUN until reset.
- Load port: active in both states. The write is visible to fetches accepted on the following cycle or later.
- ld_en in RUN forces req_ready=0 that cycle, so load beats fetch.
- req_ready = (state==RUN) & ~ld_en & (~resp_valid | resp_ready | flush).
- Accept (req_valid & req_ready): on the next edge resp_valid=1 and resp_addr=req_addr, i.e. latency 1 cycle.
  - Misaligned (req_addr[1:0]!=0): resp_fault=01, resp_inst=NOP_WORD.
  - Out of range (req_addr > DEPTH_BYTES-4, full ADDR_W unsigned compare, no truncation or wrap): resp_fault=10, resp_inst=NOP_WORD.
  - Otherwise: resp_fault=00, resp_inst = stored word.
- Back-pressure: while resp_valid & ~resp_ready & ~flush, all resp_* outputs hold stable.
- Handoff without a new accept: resp_valid -> 0 on the next edge.
- Back-to-back: with resp_ready held high, one response per cycle (full throughput).
- Flush: the held response is dropped; resp_valid=0 next edge unless a request is accepted in the same cycle, in which case the new response appears next edge (redirect).
- fetch_count increments on each resp_valid & resp_ready that is not coincident with flush.
- Reset mid-response: the response is lost, resp_valid=0; memory is preserved.

Test Plan:
- BOOT_LOAD=1: reset, load word 0=32'h00500993 and word 1=32'h07340663, pulse ld_done, fetch 0x0 then 0x4 with resp_ready=1 -> resp_inst 00500993 then 07340663, one per cycle, fault 00, fetch_count=2.
- Fetch 0x6 -> fault 01, inst 00000013. Fetch 0xFC (word 63 preloaded 32'hf8000ce3) -> ok. Fetch 0x100 -> fault 10. Fetch 0x1_0000_0000 -> fault 10, no aliasing to 0x0.
- Response pending with resp_ready=0 for 3 cycles -> req_ready=0, resp_* stable. Then resp_ready=1 -> handoff, count+1.
- Pending response, flush=1 with new req 0x8 -> old response never handed off, 0x8 response the next cycle, count unchanged by the flushed response.
- In RUN, ld_en at word 2 with req_valid at 0x8 in the same cycle -> req_ready=0. The retried fetch the next cycle returns the new data.
- Reset asserted while resp_valid=1 -> resp_valid=0, count=0, state BOOT. Fetch after ld_done returns the pre-reset contents.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Clocked instruction store: valid/ready fetch port with a 1-cycle registered read,
// word-write loader gated by a BOOT/RUN mode FSM, flush, fault reporting and a handoff counter.
module imem_fetch_unit #(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_W      = 64,
  parameter int          BOOT_LOAD   = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013,
  localparam int         LD_AW       = $clog2(DEPTH_BYTES / 4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [1:0]        resp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [LD_AW-1:0]  ld_word_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic              booting,
  output logic [31:0]       fetch_count
);

  localparam int                WORDS     = DEPTH_BYTES / 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_BYTES - 4);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t            state;
  logic [31:0]       mem [WORDS];
  logic              vld_p1;
  logic [31:0]       inst_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        fault_p1;
  logic              accept;
  logic [1:0]        fault_p0;

  // Misalignment takes priority; the range test uses the full address width so
  // high address bits can never alias back into the store.
  function automatic logic [1:0] fetch_fault(input logic [ADDR_W-1:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (a > LAST_ADDR)   return 2'b10;
    return 2'b00;
  endfunction

  assign req_ready = (state == ST_RUN) & ~ld_en & (~vld_p1 | resp_ready | flush);
  assign accept    = req_valid & req_ready;
  assign fault_p0  = fetch_fault(req_addr);

  // Loader writes are never reset so memory survives a reset pulse
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_word_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= (BOOT_LOAD != 0) ? ST_BOOT : ST_RUN;
      booting <= (BOOT_LOAD != 0);
    end else if (state == ST_BOOT && ld_done) begin
      state   <= ST_RUN;
      booting <= 1'b0;
    end
  end

  // ---- p0 -> p1: registered read / response hold ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      inst_p1     <= '0;
      addr_p1     <= '0;
      fault_p1    <= 2'b00;
      fetch_count <= '0;
    end else begin
      if (vld_p1 && resp_ready && !flush) fetch_count <= fetch_count + 32'd1;
      if (accept) begin
        vld_p1   <= 1'b1;
        addr_p1  <= req_addr;
        fault_p1 <= fault_p0;
        inst_p1  <= (fault_p0 == 2'b00) ? mem[req_addr[LD_AW+1:2]] : NOP_WORD;
      end else if (resp_ready || flush) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign resp_valid = vld_p1;
  assign resp_inst  = inst_p1;
  assign resp_addr  = addr_p1;
  assign resp_fault = fault_p1;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed scenarios then randomized traffic,
// every cycle compared against a byte-array / transaction-level reference model.
module tb_imem_fetch_unit;
  localparam int          DEPTH = 256;
  localparam int          AW    = 64;
  localparam int          LAW   = 6;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic           clk = 1'b0;
  logic           reset, req_valid, req_ready, resp_valid, resp_ready, flush;
  logic [AW-1:0]  req_addr, resp_addr;
  logic [31:0]    resp_inst, ld_data, fetch_count;
  logic [1:0]     resp_fault;
  logic           ld_en, ld_done, booting;
  logic [LAW-1:0] ld_word_addr;

  imem_fetch_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW), .BOOT_LOAD(1), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_addr(resp_addr), .resp_fault(resp_fault),
    .flush(flush), .ld_en(ld_en), .ld_word_addr(ld_word_addr), .ld_data(ld_data),
    .ld_done(ld_done), .booting(booting), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: byte-addressed store plus the single outstanding response
  logic [7:0]    m_mem [DEPTH];
  logic          m_boot, m_valid, m_fresh;
  logic [31:0]   m_inst, m_cnt;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_fault;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1; flush = 1'b0;
    ld_en = 1'b0; ld_word_addr = '0; ld_data = '0; ld_done = 1'b0;
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_valid = 1'b0; m_fresh = 1'b1;
    m_inst = '0; m_addr = '0; m_fault = 2'b00; m_cnt = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    logic       exp_rdy;
    logic [1:0] f;
    int         b;
    @(negedge clk);
    exp_rdy = !m_boot && !ld_en && (!m_valid || resp_ready || flush);
    chk("req_ready", req_ready, exp_rdy);
    chk("resp_valid", resp_valid, m_valid);
    chk("booting", booting, m_boot);
    chk("fetch_count", fetch_count, m_cnt);
    if (m_valid || m_fresh) begin
      chk("resp_inst", resp_inst, m_inst);
      chk("resp_addr", resp_addr, m_addr);
      chk("resp_fault", resp_fault, m_fault);
    end
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (m_valid && resp_ready && !flush) m_cnt++;
      if (req_valid && exp_rdy) begin
        if (req_addr % 4 != 0)        f = 2'b01;
        else if (req_addr > DEPTH - 4) f = 2'b10;
        else                           f = 2'b00;
        m_valid = 1'b1; m_fresh = 1'b0; m_addr = req_addr; m_fault = f;
        if (f != 2'b00) m_inst = NOP;
        else begin
          b = int'(req_addr);
          m_inst = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
        end
      end else if (resp_ready || flush) begin
        m_valid = 1'b0;
      end
      if (ld_en)
        for (int k = 0; k < 4; k++) m_mem[int'(ld_word_addr)*4 + k] = ld_data[8*k +: 8];
      if (m_boot && ld_done) m_boot = 1'b0;
    end
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic rr);
    req_valid = 1'b1; req_addr = a; resp_ready = rr;
    cycle();
  endtask

  logic [AW-1:0] dir_addr  [4];
  logic [1:0]    dir_fault [4];
  logic [31:0]   dir_inst  [4];
  logic [31:0]   cnt_before;
  int            sel;

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    reset = 1'b1;

    // Boot load: fill every word, with the known program words in 0, 1 and 63
    for (int w = 0; w < DEPTH / 4; w++) begin
      ld_en = 1'b1; ld_word_addr = LAW'(w);
      ld_data = (w == 0) ? 32'h00500993 : (w == 1) ? 32'h07340663 :
                (w == 63) ? 32'hf8000ce3 : $urandom;
      req_valid = (w == 5); req_addr = '0;
      cycle();
    end
    idle();
    req_valid = 1'b1;
    cycle();
    idle();
    ld_done = 1'b1;
    cycle();
    idle();
    chk("booting_cleared", booting, 1'b0);

    fetch(64'h0, 1'b1);
    chk("word0", resp_inst, 32'h00500993);
    fetch(64'h4, 1'b1);
    chk("word1", resp_inst, 32'h07340663);
    idle();
    cycle();
    chk("count_two", fetch_count, 32'd2);

    dir_addr[0] = 64'h6;         dir_fault[0] = 2'b01; dir_inst[0] = NOP;
    dir_addr[1] = 64'hFC;        dir_fault[1] = 2'b00; dir_inst[1] = 32'hf8000ce3;
    dir_addr[2] = 64'h100;       dir_fault[2] = 2'b10; dir_inst[2] = NOP;
    dir_addr[3] = 64'h1_0000_0000; dir_fault[3] = 2'b10; dir_inst[3] = NOP;
    for (int i = 0; i < 4; i++) begin
      fetch(dir_addr[i], 1'b1);
      chk("edge_fault", resp_fault, dir_fault[i]);
      chk("edge_inst", resp_inst, dir_inst[i]);
    end
    idle();
    cycle();

    // Back-pressure: response held for three cycles while a new request waits
    fetch(64'h8, 1'b0);
    for (int i = 0; i < 3; i++) fetch(64'hC, 1'b0);
    idle();
    cnt_before = m_cnt;
    cycle();
    chk("handoff_count", fetch_count, cnt_before + 32'd1);

    // Flush redirect while an unconsumed response is held
    fetch(64'h0, 1'b0);
    cnt_before = m_cnt;
    flush = 1'b1;
    fetch(64'h8, 1'b1);
    flush = 1'b0;
    chk("redirect_addr", resp_addr, 64'h8);
    chk("flush_no_count", fetch_count, cnt_before);
    idle();
    cycle();

    // Load beats fetch, retried fetch sees the new word
    ld_en = 1'b1; ld_word_addr = LAW'(2); ld_data = 32'hCAFE0123;
    fetch(64'h8, 1'b1);
    ld_en = 1'b0;
    fetch(64'h8, 1'b1);
    chk("load_then_fetch", resp_inst, 32'hCAFE0123);
    idle();

    // Reset with a response pending, then fetch the preserved contents
    fetch(64'h4, 1'b0);
    idle();
    resp_ready = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    idle();
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_count", fetch_count, 32'd0);
    cycle();
    ld_done = 1'b1;
    cycle();
    idle();
    fetch(64'h4, 1'b1);
    chk("preserved", resp_inst, 32'h07340663);
    idle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 9);
      req_valid  = ($urandom_range(0, 3) != 0);
      if (sel < 6)      req_addr = AW'({$urandom_range(0, 63), 2'b00});
      else if (sel < 7) req_addr = AW'($urandom_range(0, 255));
      else if (sel < 8) req_addr = AW'($urandom_range(252, 300));
      else              req_addr = {$urandom, $urandom};
      resp_ready   = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 9) == 0);
      ld_en        = ($urandom_range(0, 9) == 0);
      ld_word_addr = LAW'($urandom_range(0, 63));
      ld_data      = $urandom;
      ld_done      = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 499) != 0);
      if (!reset) ld_en = 1'b0;
      cycle();
    end
    idle();
    reset = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
